// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register file write port among NUM_REQ writeback sources.
// Optional per-requester grant/wait counters are enabled with `define WB_ARB_STATS_EN.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int ADDR    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_stall,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*ADDR-1:0] req_rd_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_rd_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    write_en,
  output logic [ADDR-1:0]         rd_addr,
  output logic [XLEN-1:0]         rd_data,
  output logic                    busy
`ifdef WB_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]   stat_grant_cnt,
  output logic [NUM_REQ*32-1:0]   stat_wait_cnt
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   cand;
  logic            hs;
  logic [ADDR-1:0] g_addr;
  logic [XLEN-1:0] g_data;

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    req_ready = '0;
    gidx      = '0;
    cand      = '0;
    hs        = 1'b0;
    if (!rst && !wb_stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
        if (!hs && req_valid[cand]) begin
          hs              = 1'b1;
          req_ready[cand] = 1'b1;
          gidx            = cand;
        end
      end
    end
  end

  assign g_addr = req_rd_addr[int'(gidx)*ADDR +: ADDR];
  assign g_data = req_rd_data[int'(gidx)*XLEN +: XLEN];
  assign busy   = (|req_valid) & ~(|(req_valid & req_ready));

  // Writes to x0 are still accepted so the requester retires, but never reach the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en <= 1'b0;
      rd_addr  <= '0;
      rd_data  <= '0;
      rr_ptr   <= '0;
    end else begin
      write_en <= hs && (g_addr != '0);
      if (hs && (g_addr != '0)) begin
        rd_addr <= g_addr;
        rd_data <= g_data;
      end
      if (hs) begin
        rr_ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [31:0] grant_q [NUM_REQ];
  logic [31:0] wait_q  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    // Saturating counters so long runs never wrap back to small values.
    always_ff @(posedge clk) begin
      if (rst) begin
        grant_q[i] <= '0;
        wait_q[i]  <= '0;
      end else begin
        if (req_valid[i] && req_ready[i] && (grant_q[i] != 32'hFFFF_FFFF)) begin
          grant_q[i] <= grant_q[i] + 32'd1;
        end
        if (req_valid[i] && !req_ready[i] && (wait_q[i] != 32'hFFFF_FFFF)) begin
          wait_q[i] <= wait_q[i] + 32'd1;
        end
      end
    end
    assign stat_grant_cnt[i*32 +: 32] = grant_q[i];
    assign stat_wait_cnt[i*32 +: 32]  = wait_q[i];
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scoreboard bench for regfile_wb_arbiter (3 requesters, 32-bit data, 5-bit addresses).
// Checks the WB_ARB_STATS_EN counters when that macro is defined.
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_stall;
  logic [2:0]  req_valid;
  logic [14:0] req_rd_addr;
  logic [95:0] req_rd_data;
  logic [2:0]  req_ready;
  logic        write_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy;
`ifdef WB_ARB_STATS_EN
  logic [95:0] stat_grant_cnt;
  logic [95:0] stat_wait_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [4:0]  addrs [3];
  logic [31:0] datas [3];
  logic [31:0] tbRegs [32];
  wr_t         sb [$];
  wr_t         popped;
  logic [4:0]  lastAddr = '0;
  logic [31:0] lastData = '0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(3), .XLEN(32), .ADDR(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_stall       (wb_stall),
    .req_valid      (req_valid),
    .req_rd_addr    (req_rd_addr),
    .req_rd_data    (req_rd_data),
    .req_ready      (req_ready),
    .write_en       (write_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .busy           (busy)
`ifdef WB_ARB_STATS_EN
    ,
    .stat_grant_cnt (stat_grant_cnt),
    .stat_wait_cnt  (stat_wait_cnt)
`endif
  );

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setPayload(input int i, input logic [4:0] a, input logic [31:0] d);
    addrs[i] = a;
    datas[i] = d;
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [2:0] v);
    rst       = r;
    wb_stall  = s;
    req_valid = v;
    for (int i = 0; i < 3; i++) begin
      req_rd_addr[i*5 +: 5]   = addrs[i];
      req_rd_data[i*32 +: 32] = datas[i];
    end
  endtask

  // Checks the grant mid-cycle, records the expected write, then checks the registered port.
  task automatic checkOutput(input string tag, input logic [2:0] expReady, input logic expBusy);
    logic pushed;
    pushed = 1'b0;
    @(negedge clk);
    chk({tag, "_ready"}, {29'd0, req_ready}, {29'd0, expReady});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, expBusy});
    for (int i = 0; i < 3; i++) begin
      if (expReady[i] && req_valid[i] && (addrs[i] != 5'd0)) begin
        sb.push_back('{a: addrs[i], d: datas[i]});
        pushed = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      lastAddr = '0;
      lastData = '0;
      chk({tag, "_we"}, {31'd0, write_en}, 32'd0);
      chk({tag, "_addr"}, {27'd0, rd_addr}, 32'd0);
      chk({tag, "_data"}, rd_data, 32'd0);
    end else begin
      chk({tag, "_we"}, {31'd0, write_en}, {31'd0, pushed});
      if (pushed && sb.size() > 0) begin
        popped   = sb.pop_front();
        lastAddr = popped.a;
        lastData = popped.d;
      end
      chk({tag, "_addr"}, {27'd0, rd_addr}, {27'd0, lastAddr});
      chk({tag, "_data"}, rd_data, lastData);
    end
    if (write_en === 1'b1) tbRegs[rd_addr] = rd_data;
  endtask

  initial begin
    $display("[TB] start");
    setPayload(0, 5'd1, 32'hAAAA0001);
    setPayload(1, 5'd2, 32'hAAAA0002);
    setPayload(2, 5'd3, 32'hAAAA0003);

    // Reset with every requester asking
    applyStimulus(1'b1, 1'b0, 3'b111);
    checkOutput("reset", 3'b000, 1'b1);

    // Round robin with all three continuously valid
    applyStimulus(1'b0, 1'b0, 3'b111);
    checkOutput("rr0", 3'b001, 1'b0);
    checkOutput("rr1", 3'b010, 1'b0);
    checkOutput("rr2", 3'b100, 1'b0);
    checkOutput("rr3", 3'b001, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b000);
    checkOutput("idle", 3'b000, 1'b0);

    // x0 write: accepted but dropped from the port
    setPayload(1, 5'd0, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 3'b010);
    checkOutput("x0", 3'b010, 1'b0);

    // Bring the pointer back to 0 via requester 2
    setPayload(2, 5'd9, 32'h00000009);
    applyStimulus(1'b0, 1'b0, 3'b100);
    checkOutput("wrap", 3'b100, 1'b0);

    // Same-rd collision serialised in round-robin order
    setPayload(0, 5'd5, 32'h11111111);
    setPayload(2, 5'd5, 32'h22222222);
    applyStimulus(1'b0, 1'b0, 3'b101);
    checkOutput("col0", 3'b001, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b100);
    checkOutput("col1", 3'b100, 1'b0);
    chk("col_x5", tbRegs[5], 32'h22222222);

    // Reset mid-operation with a pending request and a registered write
    applyStimulus(1'b1, 1'b0, 3'b001);
    chk("midrst_we_before", {31'd0, write_en}, 32'd1);
    checkOutput("midrst", 3'b000, 1'b1);

    // Stall scenario: registered write survives, no grants, pointer holds
    setPayload(0, 5'd7, 32'h77777777);
    setPayload(1, 5'd12, 32'hCAFE0012);
    setPayload(2, 5'd20, 32'h20202020);
    applyStimulus(1'b0, 1'b0, 3'b001);
    checkOutput("pre", 3'b001, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b110);
    chk("stall_keep_we", {31'd0, write_en}, 32'd1);
    checkOutput("stall0", 3'b000, 1'b1);
    checkOutput("stall1", 3'b000, 1'b1);
    checkOutput("stall2", 3'b000, 1'b1);
    applyStimulus(1'b0, 1'b0, 3'b110);
    checkOutput("release", 3'b010, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b100);
    checkOutput("after", 3'b100, 1'b0);

`ifdef WB_ARB_STATS_EN
    chk("stat_wait1", stat_wait_cnt[32 +: 32], 32'd3);
    chk("stat_grant1", stat_grant_cnt[32 +: 32], 32'd1);
    chk("stat_wait2", stat_wait_cnt[64 +: 32], 32'd4);
    chk("stat_grant2", stat_grant_cnt[64 +: 32], 32'd1);
    chk("stat_grant0", stat_grant_cnt[0 +: 32], 32'd1);
    chk("stat_wait0", stat_wait_cnt[0 +: 32], 32'd0);
`endif

    applyStimulus(1'b0, 1'b0, 3'b000);
    checkOutput("end", 3'b000, 1'b0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
